// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   ID->EX stage of the pipelined CPU. Drives the register-file read
//   addresses. Resolves each source operand from the register file or from
//   the EX/MEM/WB bypass paths. Detects load-use hazards and registers the
//   resolved operands into the ID/EX pipeline register, with stall, bubble
//   and flush control.
//
//   clk, rst                      clock, async active-high reset
//   id_*                          decoded instruction currently in ID
//   flush                         squash ID/EX (taken branch/jump)
//   rf_raddr1/2, rf_rdata1/2      register-file read port (combinational)
//   ex_*/mem_*/wb_* (inputs)      in-flight results usable for bypass
//   stall                         hold PC and IF/ID this cycle
//   ex_*_o                        ID/EX pipeline register
//   stall_count                   number of stall cycles, wraps at 2^32

// Resolves one source operand. The bypass is considered only when the
// instruction actually reads the source. x0 always reads as zero.
module ofs_src_resolve (
  input  logic [4:0]  rs_i,
  input  logic        use_i,
  input  logic [31:0] rf_rdata_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_regwr_i,
  input  logic        ex_is_load_i,
  input  logic [31:0] ex_data_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        mem_regwr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        wb_regwr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] op_o,
  output logic        load_hit_o
);
  always_comb begin
    op_o = rf_rdata_i;
    if (rs_i == 5'd0) begin
      op_o = '0;
    end else if (use_i) begin
      // Youngest producer wins. A load in EX has no data yet, so it cannot
      // supply a value here; that case is covered by the hazard stall.
      if (ex_regwr_i && !ex_is_load_i && ex_rd_i == rs_i)
        op_o = ex_data_i;
      else if (mem_regwr_i && mem_rd_i == rs_i)
        op_o = mem_data_i;
      else if (wb_regwr_i && wb_rd_i == rs_i)
        // The RF writes on the clock edge, so this same-cycle write is not
        // yet visible on rf_rdata.
        op_o = wb_data_i;
    end
  end

  assign load_hit_o = use_i && (rs_i != 5'd0) && ex_regwr_i && ex_is_load_i &&
                      (ex_rd_i == rs_i);
endmodule

module operand_fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_regwr,
  input  logic        id_is_load,
  input  logic        flush,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ex_regwr,
  input  logic        mem_regwr,
  input  logic        wb_regwr,
  input  logic        ex_is_load,
  input  logic [31:0] ex_data,
  input  logic [31:0] mem_data,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_op1_o,
  output logic [31:0] ex_op2_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_regwr_o,
  output logic        ex_is_load_o,
  output logic [31:0] stall_count
);
  localparam int NSRC = 2;

  logic [NSRC-1:0][4:0]  src_rs;
  logic [NSRC-1:0]       src_use;
  logic [NSRC-1:0][31:0] src_rf;
  logic [NSRC-1:0][31:0] src_op;
  logic [NSRC-1:0]       src_load_hit;

  assign src_rs  = {id_rs2, id_rs1};
  assign src_use = {id_use_rs2, id_use_rs1};
  assign src_rf  = {rf_rdata2, rf_rdata1};

  assign rf_raddr1 = id_rs1;
  assign rf_raddr2 = id_rs2;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    ofs_src_resolve u_res (
      .rs_i         (src_rs[s]),
      .use_i        (src_use[s]),
      .rf_rdata_i   (src_rf[s]),
      .ex_rd_i      (ex_rd),
      .ex_regwr_i   (ex_regwr),
      .ex_is_load_i (ex_is_load),
      .ex_data_i    (ex_data),
      .mem_rd_i     (mem_rd),
      .mem_regwr_i  (mem_regwr),
      .mem_data_i   (mem_data),
      .wb_rd_i      (wb_rd),
      .wb_regwr_i   (wb_regwr),
      .wb_data_i    (wb_data),
      .op_o         (src_op[s]),
      .load_hit_o   (src_load_hit[s])
    );
  end

  logic hazard;
  assign hazard = id_valid && (|src_load_hit);
  // A flush kills the ID instruction anyway, so it takes precedence and
  // the hazard does not count as a stall.
  assign stall  = hazard && !flush;

  logic        ex_valid_q, ex_regwr_q, ex_is_load_q;
  logic [31:0] ex_pc_q, ex_op1_q, ex_op2_q;
  logic [4:0]  ex_rd_q;
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + {31'd0, stall};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_regwr_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_pc_q      <= '0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_rd_q      <= '0;
      cnt_q        <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush || stall) begin
        // Bubble: data fields keep stale values; control must be inert.
        ex_valid_q   <= 1'b0;
        ex_regwr_q   <= 1'b0;
        ex_is_load_q <= 1'b0;
      end else begin
        ex_valid_q   <= id_valid;
        ex_regwr_q   <= id_valid && id_regwr;
        ex_is_load_q <= id_valid && id_is_load;
        ex_pc_q      <= id_pc;
        ex_op1_q     <= src_op[0];
        ex_op2_q     <= src_op[1];
        ex_rd_q      <= id_rd;
      end
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_regwr_o   = ex_regwr_q;
  assign ex_is_load_o = ex_is_load_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_op1_o     = ex_op1_q;
  assign ex_op2_o     = ex_op2_q;
  assign ex_rd_o      = ex_rd_q;
  assign stall_count  = cnt_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwr, id_is_load, flush;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_regwr, mem_regwr, wb_regwr, ex_is_load;
  logic [31:0] ex_data, mem_data, wb_data;
  logic        stall, ex_valid_o, ex_regwr_o, ex_is_load_o;
  logic [31:0] ex_pc_o, ex_op1_o, ex_op2_o, stall_count;
  logic [4:0]  ex_rd_o;

  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_regwr(id_regwr), .id_is_load(id_is_load), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
    .ex_is_load(ex_is_load), .ex_data(ex_data), .mem_data(mem_data),
    .wb_data(wb_data), .stall(stall), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
    .ex_rd_o(ex_rd_o), .ex_regwr_o(ex_regwr_o),
    .ex_is_load_o(ex_is_load_o), .stall_count(stall_count)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, op1, op2;
    logic [4:0]  rd;
    logic        regwr, isld;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Value the instruction should see: start from the architectural RF and
  // let each in-flight write, oldest to youngest, overwrite it.
  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic use_it);
    logic [31:0] v;
    if (rs == 0) return 32'd0;
    v = regs[rs];
    if (!use_it) return v;
    if (wb_regwr && wb_rd == rs) v = wb_data;
    if (mem_regwr && mem_rd == rs) v = mem_data;
    if (ex_regwr && !ex_is_load && ex_rd == rs) v = ex_data;
    return v;
  endfunction

  function automatic logic ref_hazard();
    logic pending;
    pending = id_valid && ex_regwr && ex_is_load && ex_rd != 0;
    return pending && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // Called just after a falling edge with inputs set: checks the
  // combinational outputs, queues the expected ID/EX contents after the
  // next rising edge, then waits for the following falling edge.
  task automatic step();
    exp_t e;
    logic st;
    #1;
    st = ref_hazard() && !flush;
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("raddr1", {27'd0, rf_raddr1}, {27'd0, id_rs1});
    chk("raddr2", {27'd0, rf_raddr2}, {27'd0, id_rs2});
    e = '{valid: 1'b0, pc: 32'd0, op1: 32'd0, op2: 32'd0, rd: 5'd0,
          regwr: 1'b0, isld: 1'b0, cnt: 32'd0};
    if (rst) begin
      m_cnt = 0;
    end else begin
      if (st) m_cnt = m_cnt + 1;
      if (!(flush || st)) begin
        e.valid = id_valid;
        e.pc    = id_pc;
        e.op1   = ref_operand(id_rs1, id_use_rs1);
        e.op2   = ref_operand(id_rs2, id_use_rs2);
        e.rd    = id_rd;
        e.regwr = id_valid && id_regwr;
        e.isld  = id_valid && id_is_load;
      end
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the ID/EX register presents a new value after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, e.valid});
      chk("ex_regwr", {31'd0, ex_regwr_o}, {31'd0, e.regwr});
      chk("ex_is_load", {31'd0, ex_is_load_o}, {31'd0, e.isld});
      chk("stall_count", stall_count, e.cnt);
      if (e.valid) begin
        chk("ex_pc", ex_pc_o, e.pc);
        chk("ex_op1", ex_op1_o, e.op1);
        chk("ex_op2", ex_op2_o, e.op2);
        chk("ex_rd", {27'd0, ex_rd_o}, {27'd0, e.rd});
      end
    end
  end

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic wr, input logic ld);
    id_valid = v; id_pc = $urandom; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwr = wr; id_is_load = ld;
  endtask

  task automatic set_stages(input logic exw, input logic exl, input logic [4:0] exr, input logic [31:0] exd,
                            input logic mw, input logic [4:0] mr, input logic [31:0] md,
                            input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    ex_regwr = exw; ex_is_load = exl; ex_rd = exr; ex_data = exd;
    mem_regwr = mw; mem_rd = mr; mem_data = md;
    wb_regwr = ww; wb_rd = wr; wb_data = wd;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid_o}, 32'd0);
    chk({tag, "_regwr"}, {31'd0, ex_regwr_o}, 32'd0);
    chk({tag, "_is_load"}, {31'd0, ex_is_load_o}, 32'd0);
    chk({tag, "_pc"}, ex_pc_o, 32'd0);
    chk({tag, "_op1"}, ex_op1_o, 32'd0);
    chk({tag, "_op2"}, ex_op2_o, 32'd0);
    chk({tag, "_rd"}, {27'd0, ex_rd_o}, 32'd0);
    chk({tag, "_count"}, stall_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hFFFF_FFFF;   // DUT must still read x0 as zero
    regs[5] = 32'h44;
    rst = 1'b1; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_stages(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_zero("reset");
    @(negedge clk);
    step();
    rst = 1'b0;

    // Bypass priority on rs1 = x5: EX, then MEM, then WB, then RF.
    set_id(1, 5, 0, 9, 1, 0, 1, 0);
    set_stages(1, 0, 5, 32'h11, 1, 5, 32'h22, 1, 5, 32'h33);
    step();
    set_id(1, 5, 0, 9, 1, 0, 1, 0);
    set_stages(0, 0, 5, 32'h11, 1, 5, 32'h22, 1, 5, 32'h33);
    step();
    set_id(1, 5, 0, 9, 1, 0, 1, 0);
    set_stages(0, 0, 5, 32'h11, 0, 5, 32'h22, 1, 5, 32'h33);
    step();
    set_id(1, 5, 0, 9, 1, 0, 1, 0);
    set_stages(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Load-use on rs2 = x7: one bubble, then the load data comes from MEM.
    set_id(1, 3, 7, 8, 1, 1, 1, 0);
    set_stages(1, 1, 7, 32'hBAD0, 0, 0, 0, 0, 0, 0);
    step();
    set_stages(0, 0, 0, 0, 1, 7, 32'hDEAD, 0, 0, 0);
    step();

    // Load in EX whose rd is not actually read: no stall.
    set_id(1, 7, 2, 8, 0, 1, 1, 0);
    set_stages(1, 1, 7, 32'hBAD1, 0, 0, 0, 0, 0, 0);
    step();

    // x0 is never bypassed, and a load to x0 never stalls.
    set_id(1, 0, 0, 4, 1, 1, 1, 1);
    set_stages(1, 0, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
    step();
    set_stages(1, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF);
    step();

    // Flush together with a load-use hazard: bubble, count unchanged.
    set_id(1, 6, 0, 8, 1, 0, 1, 0);
    set_stages(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Load something valid, then reset asynchronously during a stall.
    set_id(1, 5, 5, 12, 1, 1, 1, 1);
    set_stages(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_id(1, 6, 0, 8, 1, 0, 1, 0);
    set_stages(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    step();
    rst = 1'b0;

    // stall_count wrap: preset to all-ones, then two more stalls.
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    step();   // hazard inputs still applied: wraps to 0
    step();   // and on to 1

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      set_id(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      set_stages(1'($urandom), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      if (($urandom_range(0, 15)) == 0) regs[$urandom_range(1, 7)] = $urandom;
      step();
    end
    rst = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_stages(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Reader-side counterpart of the register file: the ID→EX stage of the pipelined CPU. It drives register-file read addresses, resolves each source operand from the register file or from in-flight results (EX/MEM/WB bypass), and detects load-use hazards. It registers resolved operands into the ID/EX pipeline register with stall, bubble and flush control. The register file writes on the rising edge, so a same-cycle WB write is never visible on its read ports and must be bypassed here.

## Interface
- No parameters; XLEN fixed at 32, register index width fixed at 5.
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous and active-high
- id_valid  in  1  decoded instruction present in ID
- id_pc  in  32  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5  source and destination indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2
- id_regwr  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  squash ID/EX (branch or jump taken)
- rf_raddr1, rf_raddr2  out  5  register-file read addresses (combinational, equal to id_rs1 / id_rs2)
- rf_rdata1, rf_rdata2  in  32  register-file read data (combinational)
- ex_rd, mem_rd, wb_rd  in  5  destination index in EX / MEM / WB
- ex_regwr, mem_regwr, wb_regwr  in  1  stage will write its rd
- ex_is_load  in  1  EX instruction is a load (its data is not yet available)
- ex_data, mem_data, wb_data  in  32  result available from each stage
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid_o  out  1  ID/EX valid
- ex_pc_o  out  32  registered PC
- ex_op1_o, ex_op2_o  out  32  registered resolved operands
- ex_rd_o  out  5  registered rd
- ex_regwr_o, ex_is_load_o  out  1  registered control; forced to 0 when ex_valid_o = 0
- stall_count  out  32  count of stall cycles (wraps modulo 2^32)

## Operation
- Operand resolution is per source and combinational. Priority order:
  - index 0 → 0, never bypassed;
  - ex_regwr && !ex_is_load && ex_rd == rs → ex_data;
  - mem_regwr && mem_rd == rs → mem_data;
  - wb_regwr && wb_rd == rs → wb_data;
  - otherwise rf_rdata.
- A source with id_use_rsN = 0 is never compared; its operand is rf_rdata (or 0 for x0).
- Load-use hazard: id_valid && ex_is_load && ex_regwr && ex_rd != 0 && for either used source, ex_rd == rs.
- stall = hazard && !flush.
- ID/EX register update on each rising edge, with first match winning:
  - flush: ex_valid_o ← 0;
  - stall: ex_valid_o ← 0 (bubble), ID contents unchanged upstream;
  - otherwise: ex_valid_o ← id_valid, and all ex_*_o fields ← ID values and resolved operands.
- While ex_valid_o = 0, the data fields may hold any value, but ex_regwr_o and ex_is_load_o must be 0.
- stall_count increments by 1 on every edge where stall = 1.
- A stall lasts exactly one cycle per load: the next cycle, the load is in MEM and its data arrives via mem_data.

## Timing
- Reset (asynchronous assert, released synchronously by the clock domain): every registered output goes to 0, including ex_valid_o and stall_count. Reset mid-stall discards the bubble and pending state.
- Latency: ID inputs to ex_*_o is 1 cycle.
- rf_raddr* and stall have zero latency (combinational from ID and stage inputs).
- Simultaneous flush + hazard: stall = 0, bubble inserted, stall_count unchanged.
- Simultaneous EX, MEM and WB match on the same rs: EX wins (youngest result).
- Load in EX while the ID instruction does not use that source: no stall.

## Test plan
- Reset pulse mid-run: all registered outputs read 0 immediately; stall_count = 0.
- EX=add x5=0x11, MEM writes x5=0x22, WB writes x5=0x33, RF x5=0x44; ID reads rs1=x5 → ex_op1_o=0x11 next edge. Remove the EX match → 0x22. Remove the MEM match → 0x33.
- EX=lw x7; ID=add rs2=x7 → stall=1 for 1 cycle, bubble (ex_valid_o=0, ex_regwr_o=0). Next cycle mem_data=0xDEAD → ex_op2_o=0xDEAD, stall_count=1.
- ID reads x0 while EX/MEM/WB all write x0 with 0xFFFFFFFF → operand 0, no stall.
- flush together with a load-use hazard → stall=0, ex_valid_o=0, stall_count unchanged.
- Preload stall_count to 0xFFFFFFFF via repeated stalls (or forced), one more stall → wraps to 0.
